// File: rtl/room_code_entry_pkg.sv
// Shared definitions for the room code keypad front-end: FSM state
// encoding, special key codes and default code parameters.
package room_code_entry_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ONE  = 2'd1,
        TWO  = 2'd2,
        HOLD = 2'd3
    } state_t;

    localparam logic [3:0] KEY_CLEAR  = 4'hA;
    localparam logic [3:0] KEY_ENTER  = 4'hB;

    localparam logic [7:0] DEF_PREFIX = 8'h01;
    localparam logic [7:0] DEF_LIMIT  = 8'h22;

    // A key code in 0..9 is a decimal digit.
    function automatic logic is_digit(input logic [3:0] key);
        return (key <= 4'h9);
    endfunction

endpackage

// File: rtl/entry_timer.sv
// Loadable, clearable up-counter with enable and a terminal-count flag.
// Clear has priority over load, and load has priority over count.
module entry_timer
    import room_code_entry_pkg::*;
#(
    parameter int CNT_W = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic [CNT_W-1:0] term_val,
    output logic             tc
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] count_r;

    // Counter register: clear, load or increment while enabled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= CNT_ZERO;
        end else if (clr) begin
            count_r <= CNT_ZERO;
        end else if (load) begin
            count_r <= load_val;
        end else if (en) begin
            count_r <= count_r + CNT_ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign tc = (count_r == term_val);

endmodule

// File: rtl/room_code_entry.sv
// Keypad front-end: collects up to two BCD digits, validates them against
// LIMIT on enter and presents {PREFIX, tens, ones} with a valid/ack
// handshake. Partial entries are discarded after an idle timeout.
module room_code_entry
    import room_code_entry_pkg::*;
#(
    parameter logic [7:0] PREFIX         = DEF_PREFIX,
    parameter logic [7:0] LIMIT          = DEF_LIMIT,
    parameter int         TIMEOUT_CYCLES = 1000,
    parameter int         CNT_W          = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    input  logic        code_ack,
    output logic [15:0] code_out,
    output logic        code_valid,
    output logic [7:0]  entry_digits,
    output logic        err,
    output logic        timeout
);

    localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    state_t      state_r,      state_nxt_s;
    logic [7:0]  digits_r,     digits_nxt_s;
    logic [15:0] code_out_r,   code_nxt_s;
    logic        code_valid_r, valid_nxt_s;
    logic        err_r,        err_nxt_s;
    logic        timeout_r,    timeout_nxt_s;

    logic        timer_en_s;
    logic        timer_clr_s;
    logic        timer_tc_s;

    // Idle timer runs only while a partial entry is held; any key or
    // state change restarts it.
    always_comb begin
        timer_en_s  = (state_r == ONE) || (state_r == TWO);
        timer_clr_s = key_valid || (state_nxt_s != state_r) || !timer_en_s;
    end

    entry_timer #(
        .CNT_W (CNT_W)
    ) u_entry_timer (
        .clk      (clk),
        .reset    (reset),
        .clr      (timer_clr_s),
        .en       (timer_en_s),
        .load     (1'b0),
        .load_val (CNT_ZERO),
        .term_val (TERM_CNT),
        .tc       (timer_tc_s)
    );

    // Next-state and next-output logic for the entry FSM.
    always_comb begin
        state_nxt_s   = state_r;
        digits_nxt_s  = digits_r;
        code_nxt_s    = code_out_r;
        valid_nxt_s   = code_valid_r;
        err_nxt_s     = 1'b0;
        timeout_nxt_s = 1'b0;

        case (state_r)
            IDLE: begin
                if (key_valid && is_digit(key_code)) begin
                    digits_nxt_s = {4'h0, key_code};
                    state_nxt_s  = ONE;
                end else if (key_valid && (key_code == KEY_ENTER)) begin
                    err_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end

            ONE, TWO: begin
                if (key_valid && is_digit(key_code)) begin
                    // Shift: only the last two digits are kept.
                    digits_nxt_s = {digits_r[3:0], key_code};
                    state_nxt_s  = TWO;
                end else if (key_valid && (key_code == KEY_ENTER)) begin
                    // A single digit is always in range; two are checked.
                    if ((state_r == ONE) || (digits_r <= LIMIT)) begin
                        code_nxt_s  = {PREFIX, digits_r};
                        valid_nxt_s = 1'b1;
                        state_nxt_s = HOLD;
                    end else begin
                        err_nxt_s    = 1'b1;
                        digits_nxt_s = 8'h00;
                        state_nxt_s  = IDLE;
                    end
                end else if (key_valid && (key_code == KEY_CLEAR)) begin
                    digits_nxt_s = 8'h00;
                    state_nxt_s  = IDLE;
                end else if (!key_valid && timer_tc_s) begin
                    timeout_nxt_s = 1'b1;
                    digits_nxt_s  = 8'h00;
                    state_nxt_s   = IDLE;
                end else begin
                    state_nxt_s = state_r;
                end
            end

            HOLD: begin
                // Keys are dropped until the consumer acknowledges.
                if (code_ack) begin
                    valid_nxt_s  = 1'b0;
                    digits_nxt_s = 8'h00;
                    state_nxt_s  = IDLE;
                end else begin
                    state_nxt_s = HOLD;
                end
            end

            default: begin
                valid_nxt_s  = 1'b0;
                digits_nxt_s = 8'h00;
                state_nxt_s  = IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            digits_r     <= 8'h00;
            code_out_r   <= 16'h0000;
            code_valid_r <= 1'b0;
            err_r        <= 1'b0;
            timeout_r    <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            digits_r     <= digits_nxt_s;
            code_out_r   <= code_nxt_s;
            code_valid_r <= valid_nxt_s;
            err_r        <= err_nxt_s;
            timeout_r    <= timeout_nxt_s;
        end
    end

    assign code_out     = code_out_r;
    assign code_valid   = code_valid_r;
    assign entry_digits = digits_r;
    assign err          = err_r;
    assign timeout      = timeout_r;

endmodule

// File: tb/tb_room_code_entry.sv
// Self-checking bench for room_code_entry: directed vector table,
// hand-written timeout/reset sequences and random keys against a
// digit-queue reference model.
module tb_room_code_entry;

    localparam int TC      = 24;
    localparam int LIM_DEC = 22;

    logic        clk = 1'b0;
    logic        reset;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        code_ack;
    logic [15:0] code_out;
    logic        code_valid;
    logic [7:0]  entry_digits;
    logic        err;
    logic        timeout;

    int errors = 0;
    int checks = 0;

    room_code_entry #(
        .PREFIX         (8'h01),
        .LIMIT          (8'h22),
        .TIMEOUT_CYCLES (TC),
        .CNT_W          (5)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .code_ack     (code_ack),
        .code_out     (code_out),
        .code_valid   (code_valid),
        .entry_digits (entry_digits),
        .err          (err),
        .timeout      (timeout)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int          m_q[$];
    bit          m_hold;
    logic [15:0] m_code;
    int          m_idle;
    bit          m_err;
    bit          m_to;

    function automatic logic [7:0] m_disp();
        if (m_q.size() == 0) return 8'h00;
        else if (m_q.size() == 1) return {4'h0, 4'(m_q[0])};
        else return {4'(m_q[0]), 4'(m_q[1])};
    endfunction

    function automatic logic [26:0] m_bus();
        return {m_code, m_hold, m_disp(), m_err, m_to};
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_hold = 1'b0;
        m_code = 16'h0000;
        m_idle = 0;
        m_err  = 1'b0;
        m_to   = 1'b0;
    endtask

    task automatic model_step(input logic kv, input logic [3:0] kc, input logic ack);
        int val;
        m_err = 1'b0;
        m_to  = 1'b0;
        if (m_hold) begin
            if (ack) begin
                m_hold = 1'b0;
                m_q.delete();
            end
        end else if (kv) begin
            m_idle = 0;
            if (int'(kc) <= 9) begin
                m_q.push_back(int'(kc));
                if (m_q.size() > 2) void'(m_q.pop_front());
            end else if (kc == 4'hA) begin
                m_q.delete();
            end else if (kc == 4'hB) begin
                val = (m_q.size() == 2) ? m_q[0] * 10 + m_q[1] :
                      (m_q.size() == 1) ? m_q[0] : -1;
                if (val >= 0 && val <= LIM_DEC) begin
                    m_code = {8'h01, m_disp()};
                    m_hold = 1'b1;
                end else begin
                    m_err = 1'b1;
                    m_q.delete();
                end
            end
        end else if (m_q.size() > 0) begin
            if (m_idle == TC - 1) begin
                m_to   = 1'b1;
                m_idle = 0;
                m_q.delete();
            end else begin
                m_idle++;
            end
        end
    endtask

    // ---------------- helpers ----------------
    function automatic logic [26:0] dut_bus();
        return {code_out, code_valid, entry_digits, err, timeout};
    endfunction

    task automatic check_bus(input string name, input logic [26:0] act, input logic [26:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got code=%h valid=%b digits=%h err=%b to=%b, need code=%h valid=%b digits=%h err=%b to=%b",
                     name, act[26:11], act[10], act[9:2], act[1], act[0],
                     exp[26:11], exp[10], exp[9:2], exp[1], exp[0]);
        end
    endtask

    task automatic check_val(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, need %h", name, act, exp);
        end
    endtask

    task automatic drive_cycle(input logic kv, input logic [3:0] kc, input logic ack);
        @(negedge clk);
        key_valid = kv;
        key_code  = kc;
        code_ack  = ack;
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string name, input logic kv, input logic [3:0] kc, input logic ack);
        drive_cycle(kv, kc, ack);
        model_step(kv, kc, ack);
        check_bus(name, dut_bus(), m_bus());
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        key_valid = 1'b0;
        key_code  = 4'h0;
        code_ack  = 1'b0;
        reset     = 1'b1;
        #2;
        check_bus({name, "_async"}, dut_bus(), 27'd0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        #1;
        check_bus({name, "_released"}, dut_bus(), 27'd0);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic        kv;
        logic [3:0]  kc;
        logic        ack;
        int          rep;
        logic [15:0] code;
        logic        valid;
        logic [7:0]  dig;
        logic        err;
        logic        to;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic kv, input logic [3:0] kc, input logic ack, input int rep,
                                input logic [15:0] code, input logic valid, input logic [7:0] dig,
                                input logic e, input logic t);
        vec_t v;
        v.kv = kv; v.kc = kc; v.ack = ack; v.rep = rep;
        v.code = code; v.valid = valid; v.dig = dig; v.err = e; v.to = t;
        return v;
    endfunction

    initial begin
        reset     = 1'b0;
        key_valid = 1'b0;
        key_code  = 4'h0;
        code_ack  = 1'b0;
        model_reset();

        // Keys 1,7,enter then hold; keys ignored in HOLD; ack.
        tbl.push_back(mk(1'b1, 4'h1, 1'b0,  1, 16'h0000, 1'b0, 8'h01, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 4'h7, 1'b0,  1, 16'h0000, 1'b0, 8'h17, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 4'hB, 1'b0,  1, 16'h0117, 1'b1, 8'h17, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 4'h0, 1'b0, 20, 16'h0117, 1'b1, 8'h17, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 4'h2, 1'b0,  1, 16'h0117, 1'b1, 8'h17, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 4'hB, 1'b0,  1, 16'h0117, 1'b1, 8'h17, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 4'h0, 1'b1,  1, 16'h0117, 1'b0, 8'h00, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 4'h0, 1'b1,  1, 16'h0117, 1'b0, 8'h00, 1'b0, 1'b0));
        // 23 rejected, 22 accepted.
        tbl.push_back(mk(1'b1, 4'h2, 1'b0,  1, 16'h0117, 1'b0, 8'h02, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 4'h3, 1'b0,  1, 16'h0117, 1'b0, 8'h23, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 4'hB, 1'b0,  1, 16'h0117, 1'b0, 8'h00, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 4'h0, 1'b0,  1, 16'h0117, 1'b0, 8'h00, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 4'h2, 1'b0,  1, 16'h0117, 1'b0, 8'h02, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 4'h2, 1'b0,  1, 16'h0117, 1'b0, 8'h22, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 4'hB, 1'b0,  1, 16'h0122, 1'b1, 8'h22, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 4'h0, 1'b1,  1, 16'h0122, 1'b0, 8'h00, 1'b0, 1'b0));
        // Single digit.
        tbl.push_back(mk(1'b1, 4'h5, 1'b0,  1, 16'h0122, 1'b0, 8'h05, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 4'hB, 1'b0,  1, 16'h0105, 1'b1, 8'h05, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 4'h0, 1'b1,  1, 16'h0105, 1'b0, 8'h00, 1'b0, 1'b0));
        // Shift 1,9,0 -> 90 rejected.
        tbl.push_back(mk(1'b1, 4'h1, 1'b0,  1, 16'h0105, 1'b0, 8'h01, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 4'h9, 1'b0,  1, 16'h0105, 1'b0, 8'h19, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 4'h0, 1'b0,  1, 16'h0105, 1'b0, 8'h90, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 4'hB, 1'b0,  1, 16'h0105, 1'b0, 8'h00, 1'b1, 1'b0));
        // Shift 0,9,2 -> 92 rejected.
        tbl.push_back(mk(1'b1, 4'h0, 1'b0,  1, 16'h0105, 1'b0, 8'h00, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 4'h9, 1'b0,  1, 16'h0105, 1'b0, 8'h09, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 4'h2, 1'b0,  1, 16'h0105, 1'b0, 8'h92, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 4'hB, 1'b0,  1, 16'h0105, 1'b0, 8'h00, 1'b1, 1'b0));
        // Shift 3,0,1 -> 01 accepted.
        tbl.push_back(mk(1'b1, 4'h3, 1'b0,  1, 16'h0105, 1'b0, 8'h03, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 4'h0, 1'b0,  1, 16'h0105, 1'b0, 8'h30, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 4'h1, 1'b0,  1, 16'h0105, 1'b0, 8'h01, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 4'hB, 1'b0,  1, 16'h0101, 1'b1, 8'h01, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 4'h0, 1'b1,  1, 16'h0101, 1'b0, 8'h00, 1'b0, 1'b0));
        // Key 4, clear, enter -> err; enter/ignored/clear in IDLE.
        tbl.push_back(mk(1'b1, 4'h4, 1'b0,  1, 16'h0101, 1'b0, 8'h04, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 4'hA, 1'b0,  1, 16'h0101, 1'b0, 8'h00, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 4'hB, 1'b0,  1, 16'h0101, 1'b0, 8'h00, 1'b1, 1'b0));
        tbl.push_back(mk(1'b1, 4'hC, 1'b0,  1, 16'h0101, 1'b0, 8'h00, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 4'hA, 1'b0,  1, 16'h0101, 1'b0, 8'h00, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 4'hB, 1'b0,  1, 16'h0101, 1'b0, 8'h00, 1'b1, 1'b0));
        // Ignored code in ONE, then enter accepts 02.
        tbl.push_back(mk(1'b1, 4'h2, 1'b0,  1, 16'h0101, 1'b0, 8'h02, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 4'hF, 1'b0,  1, 16'h0101, 1'b0, 8'h02, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 4'hB, 1'b0,  1, 16'h0102, 1'b1, 8'h02, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 4'h0, 1'b1,  1, 16'h0102, 1'b0, 8'h00, 1'b0, 1'b0));

        do_reset("reset_state");

        foreach (tbl[i]) begin
            for (int r = 0; r < tbl[i].rep; r++) begin
                drive_cycle(tbl[i].kv, tbl[i].kc, tbl[i].ack);
                check_bus($sformatf("tbl[%0d].%0d", i, r), dut_bus(),
                          {tbl[i].code, tbl[i].valid, tbl[i].dig, tbl[i].err, tbl[i].to});
            end
        end

        // Timeout from ONE: pulse exactly TC idle cycles after the key.
        do_reset("reset_to1");
        step("to1_key", 1'b1, 4'h1, 1'b0);
        for (int i = 1; i <= TC; i++) begin
            step($sformatf("to1_idle%0d", i), 1'b0, 4'h0, 1'b0);
            check_val($sformatf("to1_pulse%0d", i), {15'd0, timeout}, (i == TC) ? 16'd1 : 16'd0);
            check_val($sformatf("to1_digits%0d", i), {8'h00, entry_digits}, (i == TC) ? 16'h0000 : 16'h0001);
        end
        step("to1_after", 1'b0, 4'h0, 1'b0);
        check_val("to1_pulse_end", {15'd0, timeout}, 16'd0);
        step("to1_enter", 1'b1, 4'hB, 1'b0);
        check_val("to1_enter_err", {15'd0, err}, 16'd1);

        // Key on the terminal-count cycle wins over the timeout.
        step("to2_k1", 1'b1, 4'h1, 1'b0);
        step("to2_k2", 1'b1, 4'h2, 1'b0);
        for (int i = 1; i < TC; i++) step($sformatf("to2_idle%0d", i), 1'b0, 4'h0, 1'b0);
        step("to2_k3", 1'b1, 4'h3, 1'b0);
        check_val("to2_nopulse", {15'd0, timeout}, 16'd0);
        check_val("to2_digits", {8'h00, entry_digits}, 16'h0023);
        for (int i = 1; i <= TC; i++) step($sformatf("to2_tail%0d", i), 1'b0, 4'h0, 1'b0);
        check_val("to2_pulse", {15'd0, timeout}, 16'd1);

        // Reset mid-entry and in HOLD: nothing emitted afterwards.
        step("rst_k1", 1'b1, 4'h1, 1'b0);
        step("rst_k2", 1'b1, 4'h2, 1'b0);
        do_reset("rst_mid");
        for (int i = 0; i < 10; i++) step($sformatf("rst_mid_idle%0d", i), 1'b0, 4'h0, 1'b0);
        check_val("rst_mid_novalid", {15'd0, code_valid}, 16'd0);
        step("rst_h5", 1'b1, 4'h5, 1'b0);
        step("rst_hent", 1'b1, 4'hB, 1'b0);
        check_val("rst_hold_valid", {15'd0, code_valid}, 16'd1);
        do_reset("rst_hold");
        step("rst_hold_ack", 1'b0, 4'h0, 1'b1);
        check_val("rst_hold_code", code_out, 16'h0000);

        // Random keys against the model.
        do_reset("reset_rand");
        for (int n = 0; n < 4000; n++) begin
            logic       kv;
            logic [3:0] kc;
            logic       ack;
            int         sel;
            if ($urandom_range(0, 99) == 0) begin
                for (int j = 0; j < TC + 4; j++) step("rand_idle", 1'b0, 4'h0, 1'b0);
            end
            kv  = ($urandom_range(0, 99) < 40);
            sel = $urandom_range(0, 19);
            if (sel < 12)      kc = 4'($urandom_range(0, 9));
            else if (sel < 15) kc = 4'hB;
            else if (sel < 17) kc = 4'hA;
            else               kc = 4'($urandom_range(12, 15));
            ack = ($urandom_range(0, 3) == 0);
            step($sformatf("rand%0d", n), kv, kc, ack);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
